// File: rtl/snn_pkg.sv
// Shared constants for the spiking-network datapath: operand widths,
// membrane saturation bounds and the neuron FSM state encoding.
package snn_pkg;

    localparam int CUR_W   = 6;
    localparam int MEM_W   = 8;

    localparam int MEM_MAX = 127;
    localparam int MEM_MIN = -128;

    localparam logic [0:0] ST_INTEGRATE  = 1'b0;
    localparam logic [0:0] ST_REFRACTORY = 1'b1;

endpackage

// File: rtl/membrane_update.sv
// Combinational membrane step: shift-based leak, add the signed input
// current at one extra bit of headroom, then clamp to the signed range.
module membrane_update
    import snn_pkg::*;
#(
    parameter int MEM_W = snn_pkg::MEM_W
) (
    input  logic signed [MEM_W-1:0] v_i,
    input  logic signed [CUR_W-1:0] current_i,
    input  logic        [2:0]       k_i,
    output logic signed [MEM_W-1:0] vn_o
);

    localparam logic signed [MEM_W:0] SAT_MAX = {2'b00, {(MEM_W-1){1'b1}}};
    localparam logic signed [MEM_W:0] SAT_MIN = {2'b11, {(MEM_W-1){1'b0}}};

    logic signed [MEM_W-1:0] leak;
    logic signed [MEM_W:0]   v_ext;
    logic signed [MEM_W:0]   leak_ext;
    logic signed [MEM_W:0]   cur_ext;
    logic signed [MEM_W:0]   sum;

    // A zero shift must mean "no leak", not "leak everything".
    always_comb begin
        leak = '0;
        if (k_i != 3'd0) begin
            leak = v_i >>> k_i;
        end
    end

    assign v_ext    = v_i;
    assign leak_ext = leak;
    assign cur_ext  = current_i;
    assign sum      = v_ext - leak_ext + cur_ext;

    always_comb begin
        vn_o = sum[MEM_W-1:0];
        if (sum > SAT_MAX) begin
            vn_o = SAT_MAX[MEM_W-1:0];
        end else if (sum < SAT_MIN) begin
            vn_o = SAT_MIN[MEM_W-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates on enabled cycles, fires on a
// threshold crossing, then ignores input for a programmable refractory time.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int MEM_W = snn_pkg::MEM_W,
    parameter int REF_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [CUR_W-1:0] input_current,
    input  logic        [6:0]       threshold,
    input  logic        [2:0]       decay_shift,
    input  logic        [REF_W-1:0] refractory_period,
    input  logic                    reset_mode,
    output logic                    spike_out,
    output logic signed [MEM_W-1:0] membrane_potential,
    output logic                    refractory_active
);

    logic signed [MEM_W-1:0] v_q, v_d;
    logic        [0:0]       state_q, state_d;
    logic        [REF_W-1:0] cnt_q, cnt_d;
    logic                    spike_q, spike_d;

    logic signed [MEM_W-1:0] vn;
    logic signed [MEM_W-1:0] thr_ext;
    logic                    fire;

    membrane_update #(
        .MEM_W (MEM_W)
    ) u_membrane_update (
        .v_i       (v_q),
        .current_i (input_current),
        .k_i       (decay_shift),
        .vn_o      (vn)
    );

    assign thr_ext = $signed({{(MEM_W-7){1'b0}}, threshold});
    assign fire    = (vn >= thr_ext);

    always_comb begin
        v_d     = v_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        if (enable) begin
            if (state_q == ST_INTEGRATE) begin
                if (fire) begin
                    spike_d = 1'b1;
                    v_d     = reset_mode ? (vn - thr_ext) : '0;
                    if (refractory_period != '0) begin
                        cnt_d   = refractory_period;
                        state_d = ST_REFRACTORY;
                    end
                end else begin
                    v_d = vn;
                end
            end else begin
                // Potential is frozen; only the blind-period counter advances.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= REF_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_INTEGRATE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q     <= '0;
            state_q <= ST_INTEGRATE;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    assign spike_out          = spike_q;
    assign membrane_potential = v_q;
    assign refractory_active  = (state_q == ST_REFRACTORY);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: stimulus queues hand-computed expectations,
// a monitor compares them one clock later.
module tb_lif_neuron;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic signed [5:0] input_current = '0;
    logic        [6:0] threshold = 7'd20;
    logic        [2:0] decay_shift = '0;
    logic        [3:0] refractory_period = '0;
    logic              reset_mode = 1'b0;
    logic              spike_out;
    logic signed [7:0] membrane_potential;
    logic              refractory_active;

    typedef struct {
        logic signed [7:0] v;
        logic              s;
        logic              r;
        string             nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lif_neuron #(
        .MEM_W (8),
        .REF_W (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .input_current      (input_current),
        .threshold          (threshold),
        .decay_shift        (decay_shift),
        .refractory_period  (refractory_period),
        .reset_mode         (reset_mode),
        .spike_out          (spike_out),
        .membrane_potential (membrane_potential),
        .refractory_active  (refractory_active)
    );

    task automatic step(input logic rst_n, input logic en, input int cur,
                        input int thr, input int k, input int rp, input logic rm,
                        input int ev, input logic es, input logic er, input string nm);
        exp_t e;
        @(negedge clk);
        reset             = rst_n;
        enable            = en;
        input_current     = 6'(cur);
        threshold         = 7'(thr);
        decay_shift       = 3'(k);
        refractory_period = 4'(rp);
        reset_mode        = rm;
        e.v  = 8'(ev);
        e.s  = es;
        e.r  = er;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (membrane_potential !== e.v || spike_out !== e.s || refractory_active !== e.r) begin
                    failures++;
                    $display("FAIL %s: got V=%0d spike=%0b ref=%0b, expected V=%0d spike=%0b ref=%0b",
                             e.nm, membrane_potential, spike_out, refractory_active, e.v, e.s, e.r);
                end else begin
                    $display("ok   %s: V=%0d spike=%0b ref=%0b", e.nm, membrane_potential, spike_out, refractory_active);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        //    rst en  cur thr k rp rm   V   s  r   name
        step(0, 1,  31, 20, 0, 0, 0,    0, 0, 0, "reset_hold0");
        step(0, 1,  31, 20, 0, 0, 0,    0, 0, 0, "reset_hold1");
        step(0, 1,  31, 20, 0, 0, 0,    0, 0, 0, "reset_hold2");
        // Integration without leak, reset-to-zero then subtract-threshold
        step(1, 1,   7, 20, 0, 0, 0,    7, 0, 0, "int_7");
        step(1, 1,   7, 20, 0, 0, 0,   14, 0, 0, "int_14");
        step(1, 1,   7, 20, 0, 0, 0,    0, 1, 0, "fire_rm0");
        step(1, 1,   7, 20, 0, 0, 1,    7, 0, 0, "int_after_fire");
        step(1, 1,   7, 20, 0, 0, 1,   14, 0, 0, "int_14b");
        step(1, 1,   7, 20, 0, 0, 1,    1, 1, 0, "fire_rm1");
        step(1, 1,   0, 20, 0, 0, 1,    1, 0, 0, "hold_no_input");
        step(1, 0,  31, 20, 0, 0, 1,    1, 0, 0, "enable_low_hold");
        // Leak
        step(1, 1,  31,127, 0, 0, 0,   32, 0, 0, "build_32");
        step(1, 1,  31,127, 0, 0, 0,   63, 0, 0, "build_63");
        step(1, 1,   1,127, 0, 0, 0,   64, 0, 0, "build_64");
        step(1, 1,   0,127, 2, 0, 0,   48, 0, 0, "leak_k2_48");
        step(1, 1,   0,127, 2, 0, 0,   36, 0, 0, "leak_k2_36");
        step(1, 1, -32,127, 0, 0, 0,    4, 0, 0, "down_4");
        step(1, 1, -12,127, 0, 0, 0,   -8, 0, 0, "down_m8");
        step(1, 1,   0,127, 1, 0, 0,   -4, 0, 0, "leak_neg_k1");
        // Positive saturation fires at 127; negative saturation clamps silently
        step(1, 1,  31,127, 0, 0, 0,   27, 0, 0, "sat_27");
        step(1, 1,  31,127, 0, 0, 0,   58, 0, 0, "sat_58");
        step(1, 1,  31,127, 0, 0, 0,   89, 0, 0, "sat_89");
        step(1, 1,  31,127, 0, 0, 0,  120, 0, 0, "sat_120");
        step(1, 1,  31,127, 0, 0, 1,    0, 1, 0, "sat_fire_127");
        step(1, 1, -32,127, 0, 0, 0,  -32, 0, 0, "neg_m32");
        step(1, 1, -32,127, 0, 0, 0,  -64, 0, 0, "neg_m64");
        step(1, 1, -32,127, 0, 0, 0,  -96, 0, 0, "neg_m96");
        step(1, 1, -32,127, 0, 0, 0, -128, 0, 0, "neg_m128");
        step(1, 1, -32,127, 0, 0, 0, -128, 0, 0, "neg_clamp");
        // Refractory with enable gaps
        step(0, 0,   0, 20, 0, 3, 0,    0, 0, 0, "reset_pre_ref");
        step(1, 1,  31, 20, 0, 3, 0,    0, 1, 1, "ref_fire");
        step(1, 1,  31, 20, 0, 3, 0,    0, 0, 1, "ref_blind1");
        step(1, 0,  31, 20, 0, 3, 0,    0, 0, 1, "ref_gap1");
        step(1, 1,  31, 20, 0, 3, 0,    0, 0, 1, "ref_blind2");
        step(1, 0,  31, 20, 0, 3, 0,    0, 0, 1, "ref_gap2");
        step(1, 1,  31, 20, 0, 3, 0,    0, 0, 0, "ref_blind3");
        step(1, 1,  31,127, 0, 3, 0,   31, 0, 0, "ref_reintegrate");
        // Reset in the middle of a refractory period
        step(1, 1,  31, 20, 0, 3, 0,    0, 1, 1, "ref2_fire");
        step(1, 1,  31, 20, 0, 3, 0,    0, 0, 1, "ref2_blind1");
        step(0, 1,  31, 20, 0, 3, 0,    0, 0, 0, "ref2_reset");
        step(1, 1,   7, 20, 0, 3, 0,    7, 0, 0, "post_reset_int");
        // Zero refractory period: back-to-back spikes
        step(1, 1,   7,  5, 0, 0, 0,    0, 1, 0, "b2b_fire1");
        step(1, 1,   7,  5, 0, 0, 0,    0, 1, 0, "b2b_fire2");
        step(1, 1,   0,  5, 0, 0, 0,    0, 0, 0, "b2b_quiet");

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron stage sitting directly downstream of the input current calculator. Each enabled cycle it applies a shift-based leak to an 8-bit signed membrane potential, adds the 6-bit signed input current, and saturates the result. On a threshold crossing it emits a one-cycle spike, resets the potential, and enters a programmable refractory period. The spike output feeds the next layer's `input_spikes` vector.

## Interface
- `MEM_W`, default 8: membrane potential width (signed); all rules below assume 8.
- `REF_W`, default 4: refractory counter width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: update strobe. Driven one cycle after the current calculator's `enable`, so it samples that block's registered `input_current`.
- `input_current`  in  6: signed two's-complement current, range −32..31.
- `threshold`  in  7: unsigned firing threshold, 0..127.
- `decay_shift`  in  3: leak shift k; 0 = no leak.
- `refractory_period`  in  REF_W: number of enabled cycles to ignore input after a spike; 0 = none.
- `reset_mode`  in  1: selects the post-spike potential. 0 = reset to 0; 1 = subtract `threshold`.
- `spike_out`  out  1: registered spike, high for exactly one clock.
- `membrane_potential`  out  MEM_W: registered signed potential V.
- `refractory_active`  out  1: high while the FSM is in REFRACTORY.

## Operation
- FSM states: INTEGRATE, REFRACTORY. Reset state is INTEGRATE.
- INTEGRATE, with `enable`=1:
  - leak = (k==0) ? 0 : V >>> k (arithmetic shift).
  - sum = V − leak + sext(`input_current`), computed at 9 bits.
  - Vn = sum saturated to [−128, 127].
- Fire condition: Vn ≥ {0,`threshold`}, signed compare.
  - On fire: `spike_out` <= 1.
  - V <= `reset_mode` ? Vn − `threshold` : 0. The subtraction cannot underflow because Vn ≥ `threshold`.
  - If `refractory_period` ≠ 0: load counter with `refractory_period` and go to REFRACTORY.
  - Otherwise stay in INTEGRATE, so the neuron can fire again on the next enabled cycle.
- INTEGRATE, no fire: V <= Vn; `spike_out` <= 0.
- REFRACTORY, with `enable`=1:
  - `input_current` is ignored and V is held with no leak.
  - Counter decrements. When the counter equals 1 before the decrement, return to INTEGRATE.
  - The neuron is therefore blind for exactly `refractory_period` enabled cycles.
- `enable`=0: V, counter and state hold; `spike_out` <= 0.
- `threshold`, `decay_shift`, `refractory_period` and `reset_mode` are sampled only on enabled cycles. Changing them mid-refractory does not alter the counter already loaded.

## Timing
- Reset (`reset`=0, asynchronous): V=0, `spike_out`=0, `refractory_active`=0, counter=0, state=INTEGRATE. Release is synchronous to the next `clk` edge.
- Latency: 1 clock. `input_current` sampled at edge t is reflected in V and `spike_out` after edge t.
- End-to-end: the input spike vector at the calculator edge t produces a neuron spike visible after edge t+1.
- `spike_out` never stays high on two consecutive clocks unless two consecutive enabled INTEGRATE cycles both fire.
- `refractory_active` changes on the same edge as the state register.
- Reset asserted mid-refractory aborts immediately: the counter clears and no pending spike survives.

## Structure
- Shared package `snn_pkg` holds:
  - the state encoding (INTEGRATE=0, REFRACTORY=1);
  - constants `CUR_W`=6 and `MEM_W`=8;
  - saturation bounds `MEM_MAX`=127 and `MEM_MIN`=−128.
- One combinational sub-module, `membrane_update`. Inputs: V, current, k. Output: saturated Vn. The FSM, fire compare and counter stay in `lif_neuron`.

## Test plan
- Reset: hold `reset`=0, drive `input_current`=31 with `enable`=1 → V=0, `spike_out`=0, `refractory_active`=0 throughout.
- Integration, no leak: k=0, `threshold`=20, current=+7 for 3 enabled cycles.
  - V sequence is 7, 14, then 21 fires.
  - Fire cycle: `spike_out`=1 for one clock.
  - After fire: V=0 when `reset_mode`=0; V=1 when `reset_mode`=1.
- Leak:
  - V=64, k=2, current=0 → V=48, then 36.
  - V=−8, k=1, current=0 → V=−4.
- Saturation:
  - current=+31 repeatedly, `threshold`=127, k=0 → V clamps at 127 and fires on the edge where Vn=127.
  - current=−32 repeatedly → V clamps at −128, no spike.
- Refractory: `refractory_period`=3, fire, then current=+31 for 3 enabled cycles.
  - During those cycles: V held, `refractory_active`=1.
  - 4th enabled cycle integrates again.
  - Insert `enable`=0 gaps between them → the counter pauses.
- Reset mid-refractory: assert `reset` with counter=2 → next cycle state=INTEGRATE and V=0. The first enabled cycle after release integrates immediately.
